// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared types and helpers for the divided-clock rate controller:
//               controller state encoding, reset-rate half-period calculation
//               and the half-period clamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkdiv_pkg;

  // BURST is only reachable when TICK_BURST_EN is defined
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    BURST    = 2'd3
  } state_t;

  // Working width for the helper functions; callers cast to their own width
  localparam int unsigned CALC_W = 32;

  // Half period in input-clock cycles for a given output rate
  function automatic logic [CALC_W-1:0] calc_def_half(input int unsigned clk_hz,
                                                      input int unsigned def_hz);
    return CALC_W'(clk_hz / (def_hz * 2));
  endfunction

  // A zero half period cannot be counted; treat it as the fastest legal rate
  function automatic logic [CALC_W-1:0] clamp_half(input logic [CALC_W-1:0] half);
    return (half == '0) ? CALC_W'(1) : half;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_core.sv
// ============================================================================
// Module      : clkdiv_core
// Description : Half-period counter and clk_out toggle. While run is low the
//               counter and output are parked at zero. Exposes the period-end
//               strobe (compare hit while clk_out is high) to the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_core #(
  parameter int DIV_W = 26
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] active_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pe
);

  localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cntr_q, cntr_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cmpr;

  assign cmpr    = (cntr_q == (active_half - C_ONE));
  assign pe      = run & cmpr & clk_out_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

  // Next-state for counter, output level and the rising-edge tick
  always_comb begin
    cntr_d    = cntr_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (!run) begin
      cntr_d    = '0;
      clk_out_d = 1'b0;
    end else begin
      if (cmpr) begin
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end
      cntr_d = (cmpr || load) ? '0 : (cntr_q + C_ONE);
    end
  end

  // State advances on the falling edge of the system clock
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      cntr_q    <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cntr_q    <= cntr_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clkdiv_rate_ctrl.sv
// ============================================================================
// Module      : clkdiv_rate_ctrl
// Description : Run-time controller for the divided-clock path. Starts/stops
//               the divider, accepts new half periods via valid/ready and
//               applies them only at full-period boundaries (no runt pulses).
//               Optional feature macro: TICK_BURST_EN enables start/burst_len
//               bursts of N full periods with a burst_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_rate_ctrl
  import clkdiv_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned DEF_HZ  = 2,
  parameter int          DIV_W   = 26,
  parameter int          BURST_W = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [DIV_W-1:0]   cfg_half,
  output logic               cfg_ready,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic               burst_done
);

  localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(calc_def_half(CLK_HZ, DEF_HZ));

  state_t           state_q;
  logic             busy_q;
  logic [DIV_W-1:0] active_half_q;
  logic [DIV_W-1:0] pend_half_q;
  logic             pend_q;
  logic             pe;
  logic             apply;
  logic [DIV_W-1:0] cfg_clamped;

  // A pending value lands immediately when parked, otherwise at period end
  assign apply       = pend_q & ((state_q == IDLE) | pe);
  assign cfg_ready   = ~pend_q;
  assign cfg_clamped = DIV_W'(clamp_half(CALC_W'(cfg_half)));
  assign busy        = busy_q;

  clkdiv_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk_in      (clk_in),
    .rst         (rst),
    .run         (state_q != IDLE),
    .load        (apply),
    .active_half (active_half_q),
    .clk_out     (clk_out),
    .tick        (tick),
    .pe          (pe)
  );

`ifdef TICK_BURST_EN
  logic [BURST_W-1:0] remaining_q;
  logic               burst_done_q;
  assign burst_done = burst_done_q;
`else
  logic unused_burst_in;
  assign unused_burst_in = ^{start, burst_len};
  assign burst_done      = 1'b0;
`endif

  // Controller FSM; busy and burst_done are registered alongside the state
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
`ifdef TICK_BURST_EN
      remaining_q  <= '0;
      burst_done_q <= 1'b0;
`endif
    end else begin
`ifdef TICK_BURST_EN
      burst_done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
`ifdef TICK_BURST_EN
          else if (start && (burst_len != '0)) begin
            state_q     <= BURST;
            busy_q      <= 1'b1;
            remaining_q <= burst_len;
          end
`endif
        end
        RUN: begin
          if (!en) begin
            if (pe) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= STOPPING;
            end
          end
        end
        STOPPING: begin
          if (en) begin
            state_q <= RUN;
          end else if (pe) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
`ifdef TICK_BURST_EN
        BURST: begin
          if (pe) begin
            if (remaining_q == BURST_W'(1)) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              burst_done_q <= 1'b1;
            end
            remaining_q <= remaining_q - BURST_W'(1);
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Config holding register: one pending value, applied at a safe boundary
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      active_half_q <= DEF_HALF;
      pend_half_q   <= '0;
      pend_q        <= 1'b0;
    end else if (apply) begin
      active_half_q <= pend_half_q;
      pend_q        <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pend_half_q <= cfg_clamped;
      pend_q      <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_rate_ctrl.sv
// ============================================================================
// Module      : tb_clkdiv_rate_ctrl
// Description : Directed self-checking bench for clkdiv_rate_ctrl with
//               CLK_HZ=8, DEF_HZ=1 (default half period 4). Burst checks are
//               built when TICK_BURST_EN is defined; otherwise start must be
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clkdiv_rate_ctrl;

  localparam int DIV_W   = 26;
  localparam int BURST_W = 8;

  logic               clk_in;
  logic               rst;
  logic               en;
  logic               cfg_valid;
  logic [DIV_W-1:0]   cfg_half;
  logic               cfg_ready;
  logic               start;
  logic [BURST_W-1:0] burst_len;
  logic               clk_out;
  logic               tick;
  logic               busy;
  logic               burst_done;

  int checks;
  int failures;

  logic [31:0] cv, tv, bv, dv;

  clkdiv_rate_ctrl #(
    .CLK_HZ  (8),
    .DEF_HZ  (1),
    .DIV_W   (DIV_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .burst_len  (burst_len),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One active (falling) edge, then settle before sampling or driving
  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  // Capture n post-edge samples; bit i holds the value after the (i+1)-th edge
  task automatic record(input int n, output logic [31:0] c, output logic [31:0] t,
                        output logic [31:0] b, output logic [31:0] d);
    c = '0; t = '0; b = '0; d = '0;
    for (int i = 0; i < n; i++) begin
      step();
      c[i] = clk_out;
      t[i] = tick;
      b[i] = busy;
      d[i] = burst_done;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    start     = 1'b0;
    burst_len = '0;

    // Reset state
    repeat (2) step();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_burst_done", burst_done, 0);
    @(posedge clk_in);
    #1 rst = 1'b1;
    step();

`ifdef TICK_BURST_EN
    // burst_len==0 is ignored
    start = 1'b1; burst_len = 8'd0;
    step();
    start = 1'b0;
    record(6, cv, tv, bv, dv);
    chk("burst0_busy", bv, 32'h0);
    chk("burst0_tick", tv, 32'h0);
    // Three full periods, done pulse on the third period end
    start = 1'b1; burst_len = 8'd3;
    step();
    start = 1'b0;
    chk("burst_busy_enter", busy, 1);
    record(30, cv, tv, bv, dv);
    chk("burst_clk", cv, 32'h0078_7878);
    chk("burst_tick", tv, 32'h0008_0808);
    chk("burst_busy", bv, 32'h007F_FFFF);
    chk("burst_done", dv, 32'h0080_0000);
`else
    // Without bursts, start does nothing
    start = 1'b1; burst_len = 8'd3;
    step();
    start = 1'b0;
    record(10, cv, tv, bv, dv);
    chk("nob_busy", bv, 32'h0);
    chk("nob_tick", tv, 32'h0);
    chk("nob_done", dv, 32'h0);
`endif

    // Continuous run at default rate: 4 low, 4 high
    en = 1'b1;
    step();
    chk("run_busy_enter", busy, 1);
    chk("run_clk_enter", clk_out, 0);
    record(16, cv, tv, bv, dv);
    chk("run_clk", cv, 32'h7878);
    chk("run_tick", tv, 32'h0808);
    chk("run_busy", bv, 32'hFFFF);

    // Rate change offered mid high phase; applied at period end
    repeat (5) step();
    chk("rate_ready_pre", cfg_ready, 1);
    chk("rate_mid_high", clk_out, 1);
    cfg_valid = 1'b1; cfg_half = 26'd2;
    step();
    cfg_valid = 1'b0;
    chk("rate_ready_pend", cfg_ready, 0);
    step();
    chk("rate_ready_pend2", cfg_ready, 0);
    chk("rate_high_held", clk_out, 1);
    step();
    chk("rate_pe_clk", clk_out, 0);
    chk("rate_ready_back", cfg_ready, 1);
    record(8, cv, tv, bv, dv);
    chk("rate2_clk", cv, 32'h66);
    chk("rate2_tick", tv, 32'h22);

    // Back to half period 4
    cfg_valid = 1'b1; cfg_half = 26'd4;
    step();
    cfg_valid = 1'b0;
    chk("rate4_ready_pend", cfg_ready, 0);
    repeat (3) step();
    chk("rate4_ready_back", cfg_ready, 1);
    chk("rate4_pe_clk", clk_out, 0);

    // Stop requested in low phase: high phase completes, then idle
    step();
    en = 1'b0;
    step();
    chk("stop_busy_stopping", busy, 1);
    repeat (2) step();
    chk("stop_rise_tick", tick, 1);
    chk("stop_rise_clk", clk_out, 1);
    record(4, cv, tv, bv, dv);
    chk("stop_clk", cv, 32'h7);
    chk("stop_busy", bv, 32'h7);
    record(3, cv, tv, bv, dv);
    chk("idle_clk", cv, 32'h0);
    chk("idle_busy", bv, 32'h0);

    // Stop then re-enable before period end: waveform continues without a gap
    en = 1'b1;
    step();
    chk("reen_busy_enter", busy, 1);
    repeat (5) step();
    en = 1'b0;
    step();
    chk("reen_busy_stopping", busy, 1);
    en = 1'b1;
    record(8, cv, tv, bv, dv);
    chk("reen_clk", cv, 32'hE1);
    chk("reen_tick", tv, 32'h20);
    chk("reen_busy", bv, 32'hFF);

    // en dropped exactly on the period-end edge goes straight to idle
    step();
    en = 1'b0;
    step();
    chk("pe_stop_busy", busy, 0);
    chk("pe_stop_clk", clk_out, 0);

    // Zero half period clamps to 1, applied while idle
    cfg_valid = 1'b1; cfg_half = 26'd0;
    step();
    cfg_valid = 1'b0;
    chk("clamp_ready_pend", cfg_ready, 0);
    step();
    chk("clamp_ready_idle_apply", cfg_ready, 1);
    en = 1'b1;
    step();
    chk("clamp_clk_enter", clk_out, 0);
    chk("clamp_busy_enter", busy, 1);
    record(8, cv, tv, bv, dv);
    chk("clamp_clk", cv, 32'h55);
    chk("clamp_tick", tv, 32'h55);

    // Async reset mid high phase with a pending config
    cfg_valid = 1'b1; cfg_half = 26'd3;
    step();
    cfg_valid = 1'b0;
    chk("arst_pend_ready", cfg_ready, 0);
    chk("arst_pre_clk", clk_out, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_tick", tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 1);
    @(posedge clk_in);
    #1 rst = 1'b1;
    en = 1'b1;
    step();
    record(8, cv, tv, bv, dv);
    chk("arst_rate_clk", cv, 32'h78);
    chk("arst_rate_tick", tv, 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
